// File: rtl/pipe_exe_muldiv.sv
// pipe_exe_muldiv: EXE-stage multiply/divide unit owning HI/LO; pipelined MULT/MULTU,
// restoring DIV/DIVU (one quotient bit per cycle), single-cycle MTHI/MTLO.
module pipe_exe_muldiv #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_req_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;
    logic [2*WIDTH-1:0] pipe_q [MUL_LAT];
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sh, diff;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               is_mul, is_div, a_neg, b_neg, fit;

    assign is_mul      = (op_i[2:1] == 2'b00);
    assign is_div      = (op_i[2:1] == 2'b01);
    assign a_neg       = ~op_i[0] & a_i[WIDTH-1];
    assign b_neg       = ~op_i[0] & b_i[WIDTH-1];
    assign a_abs       = a_neg ? -a_i : a_i;
    assign b_abs       = b_neg ? -b_i : b_i;
    // Sign-extending to 2*WIDTH lets one unsigned multiplier serve both MULT and MULTU.
    assign prod        = {{WIDTH{a_neg}}, a_i} * {{WIDTH{b_neg}}, b_i};
    assign sh          = {rem_q, quo_q[WIDTH-1]};
    assign diff        = sh - {1'b0, dvs_q};
    assign fit         = ~diff[WIDTH];
    assign busy_o      = (state_q != S_IDLE);
    assign stall_req_o = busy_o | (start_i & ~op_i[2]);
    assign done_o      = done_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    if (is_mul) begin
                        state_d = S_MUL;
                        cnt_d   = CW'(MUL_LAT - 1);
                    end
                    if (is_div) begin
                        state_d = S_DIV;
                        cnt_d   = CW'(WIDTH - 1);
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        a_d     = a_i;
                        neg_d   = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        dz_d    = (b_i == '0);
                    end
                    if (op_i == 3'd4) hi_d = a_i;
                    if (op_i == 3'd5) lo_d = a_i;
                end
                S_MUL: begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        {hi_d, lo_d} = pipe_q[MUL_LAT-1];
                        done_d       = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
                S_DIV: begin
                    rem_d   = fit ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
                    quo_d   = {quo_q[WIDTH-2:0], fit};
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == '0) ? S_FIX : S_DIV;
                end
                default: begin
                    lo_d    = dz_q ? '1 : (neg_q ? -quo_q : quo_q);
                    hi_d    = dz_q ? a_q : (rneg_q ? -rem_q : rem_q);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    // Product enters at the accept edge and reaches the last stage MUL_LAT-1 edges later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < MUL_LAT; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= prod;
            for (int k = 1; k < MUL_LAT; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end
endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// tb_pipe_exe_muldiv: directed vectors for a 32-bit/MUL_LAT=2 and a 16-bit/MUL_LAT=4 instance,
// plus hand sequences for busy-ignore, flush, MTHI/MTLO and asynchronous reset.
module tb_pipe_exe_muldiv;
    logic        clk = 1'b0, rst_n = 1'b0, start32 = 1'b0, start16 = 1'b0, flush = 1'b0, sel16 = 1'b0;
    logic [2:0]  op = 3'd7;
    logic [31:0] a = '0, b = '0;
    logic [31:0] hi32, lo32, hi_c, lo_c;
    logic [15:0] hi16, lo16;
    logic        busy32, stall32, done32, busy16, stall16, done16, busy_c, stall_c, done_c;
    int          tests = 0, fails = 0;

    typedef struct {
        int          w;
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_exe_muldiv #(.WIDTH(32), .MUL_LAT(2)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start32), .op_i(op), .a_i(a), .b_i(b), .flush_i(flush),
        .busy_o(busy32), .stall_req_o(stall32), .done_o(done32), .hi_o(hi32), .lo_o(lo32));

    pipe_exe_muldiv #(.WIDTH(16), .MUL_LAT(4)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .op_i(op), .a_i(a[15:0]), .b_i(b[15:0]), .flush_i(flush),
        .busy_o(busy16), .stall_req_o(stall16), .done_o(done16), .hi_o(hi16), .lo_o(lo16));

    assign hi_c    = sel16 ? {16'h0, hi16} : hi32;
    assign lo_c    = sel16 ? {16'h0, lo16} : lo32;
    assign busy_c  = sel16 ? busy16 : busy32;
    assign stall_c = sel16 ? stall16 : stall32;
    assign done_c  = sel16 ? done16 : done32;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input int w, input logic [2:0] o, input logic [31:0] va, vb, eh, el);
        vec_t v;
        v.w = w; v.op = o; v.a = va; v.b = vb; v.hi = eh; v.lo = el;
        vecs.push_back(v);
    endtask

    task automatic run_op(input string nm, input vec_t v);
        int lat, n;
        lat   = (v.op[2:1] == 2'b00) ? ((v.w == 16) ? 4 : 2) : v.w + 1;
        sel16 = (v.w == 16);
        @(negedge clk);
        op = v.op; a = v.a; b = v.b;
        start32 = (v.w == 32);
        start16 = (v.w == 16);
        #1 check({nm, " stall_req"}, 32'(stall_c), 32'd1);
        @(posedge clk);
        #1 start32 = 1'b0; start16 = 1'b0;
        check({nm, " busy"}, 32'(busy_c), 32'd1);
        n = 0;
        while (!done_c && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        check({nm, " latency"}, 32'(n), 32'(lat));
        check({nm, " hi"}, hi_c, v.hi);
        check({nm, " lo"}, lo_c, v.lo);
        check({nm, " busy_at_done"}, 32'(busy_c), 32'd0);
        @(posedge clk);
        #1 check({nm, " done_pulse"}, 32'(done_c), 32'd0);
        sel16 = 1'b0;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        @(negedge clk);
        op = o; a = v; start32 = 1'b1;
        #1 check("mt stall_req", 32'(stall32), 32'd0);
        @(posedge clk);
        #1 start32 = 1'b0;
        check("mt done", 32'(done32), 32'd0);
        check("mt busy", 32'(busy32), 32'd0);
        check("mt value", (o == 3'd4) ? hi32 : lo32, v);
    endtask

    initial begin
        int n;
        logic bad;
        add(32, 3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
        add(32, 3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
        add(32, 3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        add(32, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        add(32, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        add(32, 3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        add(32, 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        add(32, 3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
        add(32, 3'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002);
        add(32, 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        add(32, 3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
        add(32, 3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
        add(32, 3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
        add(16, 3'd0, 32'h0000FFFF, 32'h00000002, 32'h0000FFFF, 32'h0000FFFE);
        add(16, 3'd1, 32'h0000FFFF, 32'h00000002, 32'h00000001, 32'h0000FFFE);
        add(16, 3'd3, 32'd100,      32'd7,        32'h00000002, 32'h0000000E);
        add(16, 3'd2, 32'h0000FFF9, 32'h00000002, 32'h0000FFFF, 32'h0000FFFD);
        add(16, 3'd2, 32'h00008000, 32'h0000FFFF, 32'h00000000, 32'h00008000);
        add(16, 3'd3, 32'h00000005, 32'h00000000, 32'h00000005, 32'h0000FFFF);

        #12;
        check("reset hi32", hi32, 32'd0);
        check("reset lo32", lo32, 32'd0);
        check("reset busy32", 32'(busy32), 32'd0);
        check("reset done32", 32'(done32), 32'd0);
        check("reset stall32", 32'(stall32), 32'd0);
        check("reset busy16", 32'(busy16), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_op($sformatf("v%0d", i), vecs[i]);

        mt(3'd4, 32'h00001234);
        mt(3'd5, 32'h00005678);

        // start held high while busy must be ignored
        @(negedge clk);
        op = 3'd3; a = 32'd100; b = 32'd7; start32 = 1'b1;
        @(posedge clk);
        #1 op = 3'd0; a = 32'hFFFFFFFF; b = 32'h2;
        bad = 1'b0; n = 0;
        while (!done32 && n < 100) begin
            if (!stall32) bad = 1'b1;
            @(posedge clk);
            #1 n++;
        end
        start32 = 1'b0;
        check("ignore stall_req", 32'(bad), 32'd0);
        check("ignore latency", 32'(n), 32'd33);
        check("ignore lo", lo32, 32'h0000000E);
        check("ignore hi", hi32, 32'h00000002);
        @(posedge clk);
        #1 check("ignore no_restart", 32'(busy32), 32'd0);

        // flush mid-DIVU
        mt(3'd4, 32'h11111111);
        mt(3'd5, 32'h22222222);
        @(negedge clk);
        op = 3'd3; a = 32'd100; b = 32'd7; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("flush busy", 32'(busy32), 32'd0);
        check("flush done", 32'(done32), 32'd0);
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done32) bad = 1'b1;
        end
        check("flush no_done", 32'(bad), 32'd0);
        check("flush hi", hi32, 32'h11111111);
        check("flush lo", lo32, 32'h22222222);
        run_op("after_flush", vecs[6]);

        // flush in IDLE suppresses MTHI and MULT
        @(negedge clk);
        flush = 1'b1; start32 = 1'b1; op = 3'd4; a = 32'h0000DEAD;
        @(posedge clk);
        #1 check("idle_flush hi", hi32, 32'hFFFFFFFF);
        op = 3'd0;
        @(posedge clk);
        #1 flush = 1'b0; start32 = 1'b0;
        check("idle_flush busy", 32'(busy32), 32'd0);

        // asynchronous reset mid-DIV on both instances
        @(negedge clk);
        op = 3'd2; a = 32'hFFFFFFF9; b = 32'h2; start32 = 1'b1; start16 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0; start16 = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("areset hi32", hi32, 32'd0);
        check("areset lo32", lo32, 32'd0);
        check("areset busy32", 32'(busy32), 32'd0);
        check("areset hi16", 32'(hi16), 32'd0);
        check("areset busy16", 32'(busy16), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("after_reset", vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
